// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: pixel-stream sequencer for the Sobel line-buffer chain
// Ports:
//   CLK          rising-edge clock
//   Reset        asynchronous active-high reset
//   Start        begin a frame (sampled only in IDLE)
//   PixelValid   source offers a pixel
//   PixelReady   controller takes a pixel (high throughout STREAM)
//   Shift_En     shared enable for the line-buffer FIFOs (= accept)
//   Window_Valid 3x3 taps hold a complete neighbourhood
//   Win_Row      row of the window centre
//   Win_Col      column of the window centre
//   Frame_Done   one-cycle pulse after the final accept
//   Busy         high in STREAM and DONE
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int CNT_W      = 7
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             PixelValid,
    output logic             PixelReady,
    output logic             Shift_En,
    output logic             Window_Valid,
    output logic [CNT_W-1:0] Win_Row,
    output logic [CNT_W-1:0] Win_Col,
    output logic             Frame_Done,
    output logic             Busy
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
    state_t r_state, w_next;
    logic [CNT_W-1:0] r_row, r_col, r_win_row, r_win_col;
    logic r_win_valid, r_frame_done;
    logic w_accept, w_last_col, w_last, w_enter;

    assign w_accept   = PixelValid && r_state == S_STREAM;
    assign w_last_col = r_col == CNT_W'(IMG_WIDTH - 1);
    assign w_last     = w_last_col && r_row == CNT_W'(IMG_HEIGHT - 1);
    assign w_enter    = r_state == S_IDLE && Start;

    always_ff @(posedge CLK or posedge Reset)
        if (Reset) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state == S_IDLE   ? (Start ? S_STREAM : S_IDLE) :
                 r_state == S_STREAM ? (w_accept && w_last ? S_DONE : S_STREAM) : S_IDLE;
    end

    always_comb begin
        PixelReady = r_state == S_STREAM;
        Busy       = r_state != S_IDLE;
        Shift_En   = w_accept;
    end

    // Raster position of the pixel offered next; cleared on frame entry.
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_enter) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_col <= w_last_col ? '0 : r_col + CNT_W'(1);
            r_row <= w_last_col ? r_row + CNT_W'(1) : r_row;
        end

    // Accepting pixel (r,c) with r,c >= 2 completes the window centred on (r-1,c-1).
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_win_valid  <= w_accept && r_row >= CNT_W'(2) && r_col >= CNT_W'(2);
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_win_row <= r_row - CNT_W'(1);
                r_win_col <= r_col - CNT_W'(1);
            end
        end

    assign Window_Valid = r_win_valid;
    assign Frame_Done   = r_frame_done;
    assign Win_Row      = r_win_row;
    assign Win_Col      = r_win_col;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: scoreboard bench for sobel_window_ctrl on an 8x6 frame
module tb_sobel_window_ctrl;
    localparam int W = 8;
    localparam int H = 6;
    localparam int CW = 7;

    logic CLK = 1'b0, Reset, Start, PixelValid;
    logic PixelReady, Shift_En, Window_Valid, Frame_Done, Busy;
    logic [CW-1:0] Win_Row, Win_Col;

    typedef struct {int r; int c;} win_t;
    win_t q[$];
    win_t w;
    int errors = 0, checks = 0;
    int m_state = 0, m_row = 0, m_col = 0;
    logic e_wv = 1'b0, e_fd = 1'b0;
    int n_rdy, n_sh, n_win, n_fd, f_row, f_col, l_row, l_col, fd_wv;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .PixelValid(PixelValid),
        .PixelReady(PixelReady), .Shift_En(Shift_En), .Window_Valid(Window_Valid),
        .Win_Row(Win_Row), .Win_Col(Win_Col), .Frame_Done(Frame_Done), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_rdy"}, 32'(PixelReady), 0);
        chk({tag, "_sh"}, 32'(Shift_En), 0);
        chk({tag, "_wv"}, 32'(Window_Valid), 0);
        chk({tag, "_row"}, 32'(Win_Row), 0);
        chk({tag, "_col"}, 32'(Win_Col), 0);
        chk({tag, "_fd"}, 32'(Frame_Done), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
    endtask

    task automatic cycle(input logic st, input logic pv);
        logic acc;
        @(negedge CLK);
        chk("wv", 32'(Window_Valid), 32'(e_wv));
        chk("fd", 32'(Frame_Done), 32'(e_fd));
        if (Window_Valid) begin
            if (q.size() == 0) chk("extra_win", 1, 0);
            else begin
                w = q.pop_front();
                chk("win_row", 32'(Win_Row), w.r);
                chk("win_col", 32'(Win_Col), w.c);
            end
            if (n_win == 0) begin f_row = 32'(Win_Row); f_col = 32'(Win_Col); end
            l_row = 32'(Win_Row);
            l_col = 32'(Win_Col);
            n_win++;
        end
        if (Frame_Done) begin n_fd++; fd_wv = 32'(Window_Valid); end
        Start = st;
        PixelValid = pv;
        #1;
        acc = pv && m_state == 1;
        chk("rdy", 32'(PixelReady), 32'(m_state == 1));
        chk("shift", 32'(Shift_En), 32'(acc));
        chk("busy", 32'(Busy), 32'(m_state != 0));
        n_rdy += 32'(PixelReady);
        n_sh += 32'(Shift_En);
        e_wv = acc && m_row >= 2 && m_col >= 2;
        e_fd = acc && m_row == H - 1 && m_col == W - 1;
        if (e_wv) q.push_back('{m_row - 1, m_col - 1});
        if (m_state == 0) begin
            if (st) begin m_state = 1; m_row = 0; m_col = 0; end
        end else if (m_state == 1) begin
            if (acc) begin
                if (e_fd) m_state = 2;
                if (m_col == W - 1) begin m_col = 0; m_row++; end
                else m_col++;
            end
        end else m_state = 0;
    endtask

    task automatic clr;
        n_rdy = 0; n_sh = 0; n_win = 0; n_fd = 0;
        f_row = -1; f_col = -1; l_row = -1; l_col = -1; fd_wv = 0;
    endtask

    // mode 0: PixelValid held high; mode 1: random stalls plus stray Start pulses
    task automatic run_frame(input int mode);
        int b;
        clr();
        cycle(1'b1, mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
        b = 0;
        while (m_state != 0 && b < 2000) begin
            cycle(mode == 1 ? (m_state == 2 || $urandom_range(0, 1) != 0) : 1'b0,
                  mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
            b++;
        end
        if (b >= 2000) chk("timeout", 1, 0);
        if (mode == 0) chk("n_rdy", n_rdy, 48);
        chk("n_shift", n_sh, 48);
        chk("n_win", n_win, 24);
        chk("n_fd", n_fd, 1);
        chk("first_row", f_row, 1);
        chk("first_col", f_col, 1);
        chk("last_row", l_row, 4);
        chk("last_col", l_col, 6);
        chk("fd_with_wv", fd_wv, 1);
        chk("q_empty", q.size(), 0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; PixelValid = 1'b0;
        #1 zero_chk("por");
        @(negedge CLK);
        Reset = 1'b0;
        clr();
        repeat (3) cycle(1'b0, 1'b1);
        chk("idle_shift_cnt", n_sh, 0);
        run_frame(0);
        repeat (2) cycle(1'b0, 1'b1);
        run_frame(1);
        cycle(1'b0, 1'b1);
        clr();
        cycle(1'b1, 1'b1);
        repeat (20) cycle(1'b0, 1'b1);
        chk("pre_rst_sh", n_sh, 20);
        #2 Reset = 1'b1;
        #1 zero_chk("mid_rst");
        m_state = 0; e_wv = 1'b0; e_fd = 1'b0; q.delete();
        @(negedge CLK);
        Reset = 1'b0;
        cycle(1'b0, 1'b0);
        run_frame(0);
        clr();
        repeat (100) cycle(1'b1, 1'b1);
        begin
            int b = 0;
            while (m_state != 0 && b < 200) begin cycle(1'b0, 1'b1); b++; end
            if (b >= 200) chk("b2b_timeout", 1, 0);
        end
        chk("b2b_rdy", n_rdy, 96);
        chk("b2b_win", n_win, 48);
        chk("b2b_fd", n_fd, 2);
        chk("b2b_sh", n_sh, 96);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
